// File: rtl/dsp_load_ctr_core.sv
// -----------------------------------------------------------------------------
// dsp_load_ctr_core
//
// Loadable up-counter with a fixed three-stage pipeline, shaped like a DSP-slice
// accumulator: input registers (stage 1), a second pipeline register (stage 2)
// and the counter / P register (stage 3). It generates address and index
// sequences that start from a programmable value.
//
// A request (enable/load/start_val) sampled at edge N acts on the counter at
// edge N+2. Loads need enable in the same sample cycle; a load without enable
// is dropped. Load has priority over increment. Increment wraps modulo
// 2^COUNTER_WIDTH.
//
// Ports:
//   i_clk        : clock, all state updates on the rising edge
//   i_rst        : synchronous active-high reset, clears every register
//   i_enable     : count/load qualifier
//   i_start_val  : value loaded when a qualified load reaches the counter
//   i_load       : load request
//   o_ctr_val    : counter value, driven straight from the counter flop
//
// Handshake: none. The block is always ready and accepts a new request on
// every clock edge; there is no backpressure and no status output.
// -----------------------------------------------------------------------------
module dsp_load_ctr_core #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [COUNTER_WIDTH-1:0] i_start_val,
  input  logic                     i_load,
  output logic [COUNTER_WIDTH-1:0] o_ctr_val
);

  // Stage 1: ungated input registers.
  logic                     r_en_s1;
  logic                     r_ld_s1;
  logic [COUNTER_WIDTH-1:0] r_sv_s1;

  // Stage 2: ungated pipeline registers.
  logic                     r_en_s2;
  logic                     r_ld_s2;
  logic [COUNTER_WIDTH-1:0] r_sv_s2;

  // Stage 3: counter register.
  logic [COUNTER_WIDTH-1:0] r_ctr;
  logic [COUNTER_WIDTH-1:0] w_ctr_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_s1 <= 1'b0;
      r_ld_s1 <= 1'b0;
      r_sv_s1 <= '0;
      r_en_s2 <= 1'b0;
      r_ld_s2 <= 1'b0;
      r_sv_s2 <= '0;
    end else begin
      r_en_s1 <= i_enable;
      r_ld_s1 <= i_load;
      r_sv_s1 <= i_start_val;
      r_en_s2 <= r_en_s1;
      r_ld_s2 <= r_ld_s1;
      r_sv_s2 <= r_sv_s1;
    end
  end

  // Load wins over increment; a load that arrives with enable low never
  // reaches this mux because en_s2 gates both paths.
  always_comb begin
    w_ctr_next = r_ctr;
    if (r_en_s2) begin
      if (r_ld_s2) begin
        w_ctr_next = r_sv_s2;
      end else begin
        w_ctr_next = r_ctr + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctr <= '0;
    end else begin
      r_ctr <= w_ctr_next;
    end
  end

  assign o_ctr_val = r_ctr;

endmodule

// File: tb/tb_dsp_load_ctr_core.sv
module tb_dsp_load_ctr_core;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [31:0] start_val;
  logic [31:0] ctr32;
  logic [7:0]  ctr8;

  always #5 clk = ~clk;

  dsp_load_ctr_core #(.COUNTER_WIDTH(32)) u_dut32 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_start_val (start_val),
    .i_load      (load),
    .o_ctr_val   (ctr32)
  );

  dsp_load_ctr_core #(.COUNTER_WIDTH(8)) u_dut8 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_start_val (start_val[7:0]),
    .i_load      (load),
    .o_ctr_val   (ctr8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // A request sampled at an edge acts two edges later. The model keeps the
  // requests sampled but not yet applied in a queue; reset empties it and
  // replaces it with two no-op requests.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        en;
    logic        ld;
    logic [31:0] sv;
  } req_t;

  req_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m32;
  logic [7:0]  m8;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic l, input logic [31:0] s);
    req_t old;
    req_t cur;
    if (r) begin
      m32 = 0;
      m8  = 0;
      pend_q.delete();
      pend_q.push_back('0);
      pend_q.push_back('0);
    end else begin
      old = pend_q.pop_front();
      if (old.en) begin
        if (old.ld) begin
          m32 = old.sv;
          m8  = old.sv[7:0];
        end else begin
          m32 = m32 + 32'd1;
          m8  = m8 + 8'd1;
        end
      end
      cur.en = e;
      cur.ld = l;
      cur.sv = s;
      pend_q.push_back(cur);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, clock one edge, update the model, check both DUTs
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic e, input logic l, input logic [31:0] s);
    rst       = r;
    enable    = e;
    load      = l;
    start_val = s;
    @(posedge clk);
    model_edge(r, e, l, s);
    #1;
    exp_q.push_back(m32);
    chk("model32", ctr32, exp_q.pop_front());
    chk("model8", {24'd0, ctr8}, {24'd0, m8});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    m32   = 0;
    m8    = 0;
    pend_q.push_back('0);
    pend_q.push_back('0);

    // Reset state.
    step(1, 0, 0, 32'd0);
    step(1, 0, 0, 32'd0);
    chk("reset", ctr32, 32'd0);

    // Loads with enable low are discarded, even after enable rises.
    step(0, 0, 1, 32'd0);
    step(0, 0, 1, 32'd5);
    step(0, 0, 0, 32'd5);
    step(0, 0, 0, 32'd0);
    chk("unqual_load", ctr32, 32'd0);

    // Enable first sampled at edge N.
    step(0, 1, 0, 32'd0);  chk("cnt_n0", ctr32, 32'd0);
    step(0, 1, 0, 32'd0);  chk("cnt_n1", ctr32, 32'd0);
    step(0, 1, 0, 32'd0);  chk("cnt_n2", ctr32, 32'd1);
    step(0, 1, 0, 32'd0);  chk("cnt_n3", ctr32, 32'd2);
    step(0, 1, 0, 32'd0);  chk("cnt_n4", ctr32, 32'd3);
    step(0, 1, 0, 32'd0);  chk("cnt_n5", ctr32, 32'd4);

    // One-cycle load of 11 while counting; start_val changes afterwards.
    step(0, 1, 1, 32'd11); chk("ld_n0", ctr32, 32'd5);
    step(0, 1, 0, 32'd77); chk("ld_n1", ctr32, 32'd6);
    step(0, 1, 0, 32'd78); chk("ld_n2", ctr32, 32'd11);
    step(0, 1, 0, 32'd0);  chk("ld_n3", ctr32, 32'd12);
    step(0, 1, 0, 32'd0);  chk("ld_n4", ctr32, 32'd13);

    // 8-bit wrap: 254, 255, 0, 1.
    step(0, 1, 1, 32'd254);
    step(0, 1, 0, 32'd0);
    step(0, 1, 0, 32'd0);  chk("wrap8_0", {24'd0, ctr8}, 32'd254);
    step(0, 1, 0, 32'd0);  chk("wrap8_1", {24'd0, ctr8}, 32'd255);
    step(0, 1, 0, 32'd0);  chk("wrap8_2", {24'd0, ctr8}, 32'd0);
    step(0, 1, 0, 32'd0);  chk("wrap8_3", {24'd0, ctr8}, 32'd1);
    chk("nowrap32", ctr32, 32'd257);

    // 32-bit wrap from all-ones.
    step(0, 1, 1, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'd0);
    step(0, 1, 0, 32'd0);  chk("wrap32_0", ctr32, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'd0);  chk("wrap32_1", ctr32, 32'd0);

    // Drop enable while at 20: 21 after M+1, then hold.
    step(0, 1, 1, 32'd18);
    step(0, 1, 0, 32'd0);
    step(0, 1, 0, 32'd0);  chk("drop_18", ctr32, 32'd18);
    step(0, 1, 0, 32'd0);  chk("drop_19", ctr32, 32'd19);
    step(0, 0, 0, 32'd0);  chk("drop_m0", ctr32, 32'd20);
    step(0, 0, 0, 32'd0);  chk("drop_m1", ctr32, 32'd21);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'd0);
      chk("drop_hold", ctr32, 32'd21);
    end

    // Reset mid-count with a load of 99 in flight.
    step(0, 1, 0, 32'd0);
    step(0, 1, 0, 32'd0);
    step(0, 1, 1, 32'd99);
    step(1, 1, 0, 32'd0);  chk("rst_mid", ctr32, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'd0);
      chk("rst_no99", ctr32, 32'd0);
    end
    step(0, 1, 0, 32'd0);  chk("resume_0", ctr32, 32'd0);
    step(0, 1, 0, 32'd0);  chk("resume_1", ctr32, 32'd0);
    step(0, 1, 0, 32'd0);  chk("resume_2", ctr32, 32'd1);

    // Held load reloads each cycle.
    step(0, 1, 1, 32'd40);
    step(0, 1, 1, 32'd50);
    step(0, 1, 1, 32'd60);  chk("hold_ld_0", ctr32, 32'd40);
    step(0, 1, 0, 32'd0);   chk("hold_ld_1", ctr32, 32'd50);
    step(0, 1, 0, 32'd0);   chk("hold_ld_2", ctr32, 32'd60);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        e;
      logic        l;
      logic [31:0] s;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(r, e, l, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
